rca_att_multi: RTL and testbench

Parametrised Accelerator Trigger Table for the Taiga fetch stage. It holds `NUM_ENTRIES` trigger entries, each a loop-start PC plus a software-basic-block (SBB) address. When a valid entry matches the fetch PC, it injects a two-instruction RCA use sequence: a feedback (FB) instruction, then a non-feedback (NFB) instruction with redirect to the SBB address. Unlike the fixed single-cycle trigger, the sequence is held against fetch backpressure and abortable by flush. Entries are programmed through a CPU issue/writeback handshake, with optional per-entry trigger counters.

---
 rtl/rca_att_multi.sv | 205 ++++++++++++++++++++
 tb/tb_rca_att_multi.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_att_multi.sv
// Accelerator Trigger Table: injects an FB/NFB RCA instruction pair when the fetch PC hits a loop start.
// Optional per-entry trigger counters are enabled by defining RCA_ATT_TRIGGER_COUNT_EN.
module rca_att_multi #(
    parameter  int XLEN        = 32,
    parameter  int NUM_ENTRIES = 4,
    parameter  int ID_W        = 3,
    parameter  int COUNT_W     = 16,
    localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             if_valid,
    input  logic             fetch_ready,
    input  logic             flush,
    output logic             att_override,
    output logic [31:0]      override_instr,
    output logic [XLEN-1:0]  next_pc_override,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_entry,
    input  logic [1:0]       cfg_field,
    input  logic [XLEN-1:0]  cfg_wdata,
    input  logic [ID_W-1:0]  cfg_id,
    output logic             wb_done,
    input  logic             wb_ack,
    output logic [ID_W-1:0]  wb_id,
    output logic [XLEN-1:0]  wb_rd
);

    if (NUM_ENTRIES < 1 || NUM_ENTRIES > 8) begin : g_bad_entries
        $error("NUM_ENTRIES must be in 1..8");
    end
    if (COUNT_W < 1 || COUNT_W > XLEN) begin : g_bad_count_w
        $error("COUNT_W must be in 1..XLEN");
    end

    typedef enum logic {
        IDLE,
        INJ_NFB
    } state_t;

    localparam logic [1:0] FIELD_SBB   = 2'd0;
    localparam logic [1:0] FIELD_LOOP  = 2'd1;
    localparam logic [1:0] FIELD_VALID = 2'd2;
    localparam logic [1:0] FIELD_COUNT = 2'd3;

    localparam logic [31:0] FB_BASE = 32'h0000_002b;
    localparam logic [31:0] NFB_BIT = 32'h0200_0000;

    function automatic logic [31:0] fb_instr(input logic [IDX_W-1:0] idx);
        return FB_BASE | (32'(idx) << 12);
    endfunction

    // Trigger table
    logic [XLEN-1:0] sbb_addr        [NUM_ENTRIES];
    logic [XLEN-1:0] loop_start_addr [NUM_ENTRIES];
    logic            entry_valid     [NUM_ENTRIES];

    state_t           state;
    logic [IDX_W-1:0] lat_idx;
    logic [XLEN-1:0]  lat_sbb;

    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;
    logic [XLEN-1:0]  hit_sbb;
    logic             fb_accept;
    logic             cfg_accept;
    logic [XLEN-1:0]  rd_val;

    // Scanning downward lets the lowest matching index overwrite higher ones.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hit_any = 1'b0;
        hit_idx = '0;
        hit_sbb = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (if_valid && entry_valid[i] && (if_pc == loop_start_addr[i])) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
                hit_sbb = sbb_addr[i];
            end
        end
    end

    assign fb_accept  = (state == IDLE) && hit_any && fetch_ready && !flush;
    assign cfg_ready  = !wb_done;
    assign cfg_accept = cfg_valid && cfg_ready;

    always_comb begin
        att_override     = 1'b0;
        override_instr   = '0;
        next_pc_override = '0;
        case (state)
            IDLE: begin
                if (hit_any) begin
                    att_override     = 1'b1;
                    override_instr   = fb_instr(hit_idx);
                    next_pc_override = if_pc + XLEN'(4);
                end
            end
            INJ_NFB: begin
                if (!flush) begin
                    att_override     = 1'b1;
                    override_instr   = fb_instr(lat_idx) | NFB_BIT;
                    next_pc_override = lat_sbb;
                end
            end
            default: ;
        endcase
    end

    // The NFB half uses the index and SBB captured at FB acceptance, immune to later table writes.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state   <= IDLE;
            lat_idx <= '0;
            lat_sbb <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fb_accept) begin
                        state   <= INJ_NFB;
                        lat_idx <= hit_idx;
                        lat_sbb <= hit_sbb;
                    end
                end
                INJ_NFB: begin
                    if (fetch_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the table is small and must come up invalid, so it is reset like ordinary flops, not as a RAM.
        if (!rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                sbb_addr[i]        <= '0;
                loop_start_addr[i] <= '0;
                entry_valid[i]     <= 1'b0;
            end
        end else if (cfg_accept) begin
            // An out-of-range cfg_entry matches no i and therefore writes nothing.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (cfg_entry == IDX_W'(i)) begin
                    case (cfg_field)
                        FIELD_SBB:   sbb_addr[i]        <= cfg_wdata;
                        FIELD_LOOP:  loop_start_addr[i] <= cfg_wdata;
                        FIELD_VALID: entry_valid[i]     <= cfg_wdata[0];
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef RCA_ATT_TRIGGER_COUNT_EN
    logic [COUNT_W-1:0] trig_count [NUM_ENTRIES];

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cfg_field == FIELD_COUNT && cfg_entry == IDX_W'(i)) rd_val = XLEN'(trig_count[i]);
        end
    end

    // Clear beats a coincident increment; counters saturate at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) trig_count[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (cfg_accept && cfg_field == FIELD_COUNT && cfg_entry == IDX_W'(i)) begin
                    trig_count[i] <= '0;
                end else if (fb_accept && hit_idx == IDX_W'(i) && trig_count[i] != '1) begin
                    trig_count[i] <= trig_count[i] + COUNT_W'(1);
                end
            end
        end
    end
`else
    assign rd_val = '0;
`endif

    // Writeback handshake: a new acceptance wins over a coincident ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_done <= 1'b0;
            wb_id   <= '0;
            wb_rd   <= '0;
        end else if (cfg_accept) begin
            wb_done <= 1'b1;
            wb_id   <= cfg_id;
            wb_rd   <= rd_val;
        end else if (wb_ack) begin
            wb_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rca_att_multi.sv
// Directed self-checking bench for rca_att_multi (counter expectations follow RCA_ATT_TRIGGER_COUNT_EN).
module tb_rca_att_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        fetch_ready;
    logic        flush;
    logic        att_override;
    logic [31:0] override_instr;
    logic [31:0] next_pc_override;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_entry;
    logic [1:0]  cfg_field;
    logic [31:0] cfg_wdata;
    logic [2:0]  cfg_id;
    logic        wb_done;
    logic        wb_ack;
    logic [2:0]  wb_id;
    logic [31:0] wb_rd;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] rd;

`ifdef RCA_ATT_TRIGGER_COUNT_EN
    localparam logic [31:0] EXP_COUNT = 32'd5;
`else
    localparam logic [31:0] EXP_COUNT = 32'd0;
`endif

    rca_att_multi dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .if_valid         (if_valid),
        .fetch_ready      (fetch_ready),
        .flush            (flush),
        .att_override     (att_override),
        .override_instr   (override_instr),
        .next_pc_override (next_pc_override),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_entry        (cfg_entry),
        .cfg_field        (cfg_field),
        .cfg_wdata        (cfg_wdata),
        .cfg_id           (cfg_id),
        .wb_done          (wb_done),
        .wb_ack           (wb_ack),
        .wb_id            (wb_id),
        .wb_rd            (wb_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ovr(input string tag, input logic ovr, input logic [31:0] instr,
                             input logic [31:0] npc);
        check({tag, "_ovr"}, att_override, ovr);
        check({tag, "_instr"}, override_instr, instr);
        check({tag, "_npc"}, next_pc_override, npc);
    endtask

    task automatic cfg_write(input logic [1:0] e, input logic [1:0] f, input logic [31:0] d,
                             input logic [2:0] id, output logic [31:0] rdata);
        int n = 0;
        while (!cfg_ready && n < 20) begin
            tick();
            n++;
        end
        check("cfg_ready_wait", cfg_ready, 1'b1);
        cfg_valid = 1'b1;
        cfg_entry = e;
        cfg_field = f;
        cfg_wdata = d;
        cfg_id    = id;
        tick();
        cfg_valid = 1'b0;
        check("cfg_wb_done", wb_done, 1'b1);
        check("cfg_wb_id", wb_id, id);
        rdata  = wb_rd;
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        if_pc = '0; if_valid = 1'b0; fetch_ready = 1'b0; flush = 1'b0;
        cfg_valid = 1'b0; cfg_entry = '0; cfg_field = '0; cfg_wdata = '0; cfg_id = '0;
        wb_ack = 1'b0;
        #2;
        check_ovr("reset", 1'b0, 32'h0, 32'h0);
        check("reset_cfg_ready", cfg_ready, 1'b1);
        check("reset_wb_done", wb_done, 1'b0);
        check("reset_wb_id", wb_id, 3'd0);
        check("reset_wb_rd", wb_rd, 32'h0);
        tick(); tick();
        rst = 1'b1;

        // Basic trigger on entry 2
        cfg_write(2'd2, 2'd0, 32'h400, 3'd1, rd);
        check("sbb_wr_rd", rd, 32'h0);
        cfg_write(2'd2, 2'd1, 32'h100, 3'd2, rd);
        cfg_write(2'd2, 2'd2, 32'h1,   3'd3, rd);
        if_pc = 32'h100; if_valid = 1'b1; fetch_ready = 1'b1;
        #1;
        check_ovr("basic_fb", 1'b1, 32'h0000202b, 32'h104);
        tick();
        if_pc = 32'h104;
        check_ovr("basic_nfb", 1'b1, 32'h0200202b, 32'h400);
        tick();
        if_valid = 1'b0;
        #1;
        check("basic_done_ovr", att_override, 1'b0);

        // Backpressure holds FB
        if_pc = 32'h100; if_valid = 1'b1; fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_ovr("bp_hold_fb", 1'b1, 32'h0000202b, 32'h104);
            tick();
        end
        fetch_ready = 1'b1;
        #1;
        check_ovr("bp_fb", 1'b1, 32'h0000202b, 32'h104);
        tick();
        check_ovr("bp_nfb", 1'b1, 32'h0200202b, 32'h400);
        tick();
        if_valid = 1'b0; fetch_ready = 1'b0;

        // Lowest index wins
        cfg_write(2'd1, 2'd1, 32'h200, 3'd4, rd);
        cfg_write(2'd1, 2'd2, 32'h1,   3'd5, rd);
        cfg_write(2'd3, 2'd1, 32'h200, 3'd6, rd);
        cfg_write(2'd3, 2'd2, 32'h1,   3'd7, rd);
        if_pc = 32'h200; if_valid = 1'b1; fetch_ready = 1'b1;
        #1;
        check_ovr("prio_fb", 1'b1, 32'h0000102b, 32'h204);
        tick();
        check("prio_nfb_instr", override_instr, 32'h0200102b);
        tick();
        if_valid = 1'b0; fetch_ready = 1'b0;

        // Rewrite entry 0 while its NFB is pending
        cfg_write(2'd0, 2'd0, 32'h600, 3'd1, rd);
        cfg_write(2'd0, 2'd1, 32'h300, 3'd2, rd);
        cfg_write(2'd0, 2'd2, 32'h1,   3'd3, rd);
        if_pc = 32'h300; if_valid = 1'b1; fetch_ready = 1'b1;
        #1;
        check_ovr("rw_fb", 1'b1, 32'h0000002b, 32'h304);
        tick();
        fetch_ready = 1'b0; if_valid = 1'b0;
        cfg_valid = 1'b1; cfg_entry = 2'd0; cfg_field = 2'd0; cfg_wdata = 32'h800; cfg_id = 3'd5;
        tick();
        cfg_valid = 1'b0;
        check_ovr("rw_nfb_old_sbb", 1'b1, 32'h0200002b, 32'h600);
        check("rw_wb_id", wb_id, 3'd5);
        wb_ack = 1'b1; fetch_ready = 1'b1;
        tick();
        wb_ack = 1'b0; fetch_ready = 1'b0;
        check("rw_wb_cleared", wb_done, 1'b0);
        if_pc = 32'h300; if_valid = 1'b1; fetch_ready = 1'b1;
        tick();
        if_valid = 1'b0; fetch_ready = 1'b0;
        check("rw_nfb_new_sbb", next_pc_override, 32'h800);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;

        // Flush in INJ_NFB
        if_pc = 32'h300; if_valid = 1'b1; fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0; flush = 1'b1;
        #1;
        check("flush_ovr", att_override, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        check_ovr("flush_back_idle", 1'b1, 32'h0000002b, 32'h304);
        if_valid = 1'b0;

        // Handshake with delayed ack
        cfg_valid = 1'b1; cfg_entry = 2'd1; cfg_field = 2'd0; cfg_wdata = 32'h1000; cfg_id = 3'd3;
        tick();
        cfg_entry = 2'd3; cfg_wdata = 32'h2000; cfg_id = 3'd6;
        check("hs_done1", wb_done, 1'b1);
        check("hs_id1", wb_id, 3'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hs_ready_low", cfg_ready, 1'b0);
            check("hs_id_held", wb_id, 3'd3);
        end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("hs_ready_after_ack", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
        check("hs_done2", wb_done, 1'b1);
        check("hs_id2", wb_id, 3'd6);
        check("hs_rd2", wb_rd, 32'h0);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("hs_done_clr", wb_done, 1'b0);
        if_pc = 32'h200; if_valid = 1'b1; fetch_ready = 1'b1;
        tick();
        if_valid = 1'b0;
        check("hs_entry1_sbb", next_pc_override, 32'h1000);
        tick();
        fetch_ready = 1'b0;

        // Trigger counter for entry 1
        cfg_write(2'd1, 2'd3, 32'h0, 3'd2, rd);
        for (int i = 0; i < 5; i++) begin
            if_pc = 32'h200; if_valid = 1'b1; fetch_ready = 1'b1;
            tick();
            if_valid = 1'b0;
            tick();
            fetch_ready = 1'b0;
        end
        cfg_write(2'd1, 2'd3, 32'h0, 3'd4, rd);
        check("count_read", rd, EXP_COUNT);
        cfg_write(2'd1, 2'd3, 32'h0, 3'd5, rd);
        check("count_cleared", rd, 32'h0);

        // Asynchronous reset mid-sequence
        if_pc = 32'h100; if_valid = 1'b1; fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        check("rst_pre_nfb", att_override, 1'b1);
        #1 rst = 1'b0;
        #1;
        check_ovr("rst_async", 1'b0, 32'h0, 32'h0);
        check("rst_async_ready", cfg_ready, 1'b1);
        check("rst_async_wb_id", wb_id, 3'd0);
        tick();
        rst = 1'b1;
        #1;
        check("rst_table_cleared", att_override, 1'b0);
        if_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
